// File: rtl/gt_rx_comma_aligner.sv
// Comma aligner for decoded 8b/10b words. It hunts for the comma byte, verifies and locks on
// a stable offset, and re-packs each word so the comma lands in byte 0.
module gt_rx_comma_aligner #(
  parameter int         BYTES       = 4,
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         LOCK_COUNT  = 3,
  parameter int         UNLOCK_ERRS = 4
) (
  input  logic                       sysclk_in,
  input  logic                       soft_reset_rx_in,
  input  logic                       rx_valid_in,
  input  logic [8*BYTES-1:0]         rx_data_in,
  input  logic [BYTES-1:0]           rx_charisk_in,
  input  logic [BYTES-1:0]           rx_disperr_in,
  input  logic [BYTES-1:0]           rx_notintable_in,
  output logic [8*BYTES-1:0]         aligned_data_out,
  output logic [BYTES-1:0]           aligned_charisk_out,
  output logic                       aligned_valid_out,
  output logic                       locked_out,
  output logic [$clog2(BYTES)-1:0]   offset_out,
  output logic                       realign_out,
  output logic [15:0]                err_count_out,
  output logic [1:0]                 dbg_state
);
  localparam int OW = $clog2(BYTES);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Handshake: rx_valid_in qualifies one word per clock with no back-pressure; aligned_valid_out
  // is a one-cycle qualifier for aligned_data_out/aligned_charisk_out and is only ever high while locked.
  state_t               state_q, state_d;
  logic [OW-1:0]        offset_q, offset_d;
  logic [3:0]           good_q, good_d, bad_q, bad_d;
  logic [8*BYTES-1:0]   prev_data_q;
  logic [BYTES-1:0]     prev_k_q;
  logic                 loaded_q;

  logic                 has_comma;
  logic [OW-1:0]        pos;
  logic                 code_err;
  logic                 emit;
  logic [8*BYTES-1:0]   aligned_data;
  logic [BYTES-1:0]     aligned_k;

  assign code_err = |(rx_disperr_in | rx_notintable_in);

  // Descending scan so the lowest-index comma is the one left standing.
  always_comb begin
    has_comma = 1'b0;
    pos       = '0;
    for (int i = BYTES - 1; i >= 0; i--) begin
      if (rx_charisk_in[i] && (rx_data_in[8*i +: 8] == COMMA)) begin
        has_comma = 1'b1;
        pos       = OW'(i);
      end
    end
  end

  // Byte j of the output is byte (j + offset) of the stream {cur, prev}.
  always_comb begin
    aligned_data = '0;
    aligned_k    = '0;
    for (int j = 0; j < BYTES; j++) begin
      if (j + int'(offset_q) < BYTES) begin
        aligned_data[8*j +: 8] = prev_data_q[8*(j + int'(offset_q)) +: 8];
        aligned_k[j]           = prev_k_q[j + int'(offset_q)];
      end else begin
        aligned_data[8*j +: 8] = rx_data_in[8*(j + int'(offset_q) - BYTES) +: 8];
        aligned_k[j]           = rx_charisk_in[j + int'(offset_q) - BYTES];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    good_d   = good_q;
    bad_d    = bad_q;
    if (rx_valid_in) begin
      case (state_q)
        HUNT: begin
          if (has_comma && !code_err) begin
            offset_d = pos;
            good_d   = 4'd1;
            bad_d    = 4'd0;
            state_d  = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (code_err) begin
            state_d = HUNT;
          end else if (has_comma) begin
            if (pos == offset_q) begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == 4'(LOCK_COUNT)) begin
                state_d = LOCKED;
                bad_d   = 4'd0;
              end
            end else begin
              offset_d = pos;
              good_d   = 4'd1;
            end
          end
        end
        LOCKED: begin
          // An error wins over a good comma in the same word.
          if (code_err || (has_comma && (pos != offset_q))) begin
            bad_d = bad_q + 4'd1;
            if (bad_q + 4'd1 == 4'(UNLOCK_ERRS)) state_d = HUNT;
          end else if (has_comma) begin
            bad_d = 4'd0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign emit = rx_valid_in && loaded_q && (state_d == LOCKED);

  always_ff @(posedge sysclk_in) begin
    if (soft_reset_rx_in) begin
      state_q             <= HUNT;
      offset_q            <= '0;
      good_q              <= 4'd0;
      bad_q               <= 4'd0;
      prev_data_q         <= '0;
      prev_k_q            <= '0;
      loaded_q            <= 1'b0;
      aligned_data_out    <= '0;
      aligned_charisk_out <= '0;
      aligned_valid_out   <= 1'b0;
      realign_out         <= 1'b0;
      err_count_out       <= 16'd0;
    end else begin
      state_q           <= state_d;
      offset_q          <= offset_d;
      good_q            <= good_d;
      bad_q             <= bad_d;
      realign_out       <= (offset_d != offset_q);
      aligned_valid_out <= emit;
      if (emit) begin
        aligned_data_out    <= aligned_data;
        aligned_charisk_out <= aligned_k;
      end
      if (rx_valid_in) begin
        prev_data_q <= rx_data_in;
        prev_k_q    <= rx_charisk_in;
        loaded_q    <= 1'b1;
        if (code_err && (err_count_out != 16'hFFFF)) err_count_out <= err_count_out + 16'd1;
      end
    end
  end

  assign locked_out = (state_q == LOCKED);
  assign offset_out = offset_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_gt_rx_comma_aligner.sv
// Bench for gt_rx_comma_aligner: directed scenarios plus a randomized run, all checked against
// a word-level reference model and an expected-output queue.
module tb_gt_rx_comma_aligner;
  localparam int B = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic              rx_valid = 1'b0;
  logic [8*B-1:0]    rx_data  = '0;
  logic [B-1:0]      rx_k     = '0;
  logic [B-1:0]      rx_de    = '0;
  logic [B-1:0]      rx_nt    = '0;
  logic [8*B-1:0]    aligned_data_out;
  logic [B-1:0]      aligned_charisk_out;
  logic              aligned_valid_out;
  logic              locked_out;
  logic [1:0]        offset_out;
  logic              realign_out;
  logic [15:0]       err_count_out;
  logic [1:0]        dbg_state;

  gt_rx_comma_aligner #(.BYTES(B), .COMMA(8'hBC), .LOCK_COUNT(3), .UNLOCK_ERRS(4)) dut (
    .sysclk_in           (clk),
    .soft_reset_rx_in    (rst),
    .rx_valid_in         (rx_valid),
    .rx_data_in          (rx_data),
    .rx_charisk_in       (rx_k),
    .rx_disperr_in       (rx_de),
    .rx_notintable_in    (rx_nt),
    .aligned_data_out    (aligned_data_out),
    .aligned_charisk_out (aligned_charisk_out),
    .aligned_valid_out   (aligned_valid_out),
    .locked_out          (locked_out),
    .offset_out          (offset_out),
    .realign_out         (realign_out),
    .err_count_out       (err_count_out),
    .dbg_state           (dbg_state)
  );

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int realign_cnt = 0;
  logic [8*B-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (word level) ----------------
  // mode: 0 = hunting, 1 = verifying, 2 = locked
  int             m_mode, m_off, m_good, m_bad, m_err;
  bit             m_loaded;
  logic [8*B-1:0] m_prev;
  logic [B-1:0]   m_prev_k;
  bit             e_valid, e_realign;
  logic [8*B-1:0] e_data;
  logic [B-1:0]   e_k;

  function automatic int find_comma(input logic [8*B-1:0] d, input logic [B-1:0] k);
    for (int i = 0; i < B; i++)
      if (k[i] && d[8*i +: 8] == 8'hBC) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_off = 0; m_good = 0; m_bad = 0; m_err = 0;
    m_loaded = 0; m_prev = '0; m_prev_k = '0;
    e_valid = 0; e_realign = 0; e_data = '0; e_k = '0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [8*B-1:0] d, input logic [B-1:0] k, input bit err);
    int pos, old, idx;
    logic [8*B-1:0] al;
    logic [B-1:0] ak;
    logic [8*B-1:0] bytes_all [2];
    pos = find_comma(d, k);
    old = m_off;
    for (int j = 0; j < B; j++) begin
      idx = j + m_off;
      if (idx < B) begin al[8*j +: 8] = m_prev[8*idx +: 8]; ak[j] = m_prev_k[idx]; end
      else begin al[8*j +: 8] = d[8*(idx-B) +: 8]; ak[j] = k[idx-B]; end
    end
    bytes_all[0] = al;
    if (m_mode == 0) begin
      if (pos >= 0 && !err) begin m_off = pos; m_good = 1; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (err) m_mode = 0;
      else if (pos == m_off) begin
        m_good++;
        if (m_good >= 3) begin m_mode = 2; m_bad = 0; end
      end else if (pos >= 0) begin
        m_off = pos; m_good = 1;
      end
    end else begin
      if (err || (pos >= 0 && pos != m_off)) begin
        m_bad++;
        if (m_bad >= 4) m_mode = 0;
      end else if (pos >= 0) m_bad = 0;
    end
    e_realign = (m_off != old);
    e_valid   = m_loaded && (m_mode == 2);
    if (e_valid) begin e_data = bytes_all[0]; e_k = ak; exp_q.push_back(bytes_all[0]); end
    if (err && m_err < 65535) m_err++;
    m_prev = d; m_prev_k = k; m_loaded = 1;
  endtask

  task automatic compare_all();
    check("locked", locked_out, m_mode == 2);
    check("valid", aligned_valid_out, e_valid);
    check("offset", offset_out, m_off);
    check("realign", realign_out, e_realign);
    check("err_count", err_count_out, m_err);
    check("data_hold", aligned_data_out, e_data);
    check("charisk", aligned_charisk_out, e_k);
    if (realign_out) realign_cnt++;
    if (aligned_valid_out) begin
      if (exp_q.size() == 0) check("sb_unexpected_valid", 1, 0);
      else check("sb_data", aligned_data_out, exp_q.pop_front());
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic v, input logic [8*B-1:0] d, input logic [B-1:0] k,
                      input logic [B-1:0] de, input logic [B-1:0] nt);
    rx_valid = v; rx_data = d; rx_k = k; rx_de = de; rx_nt = nt;
    @(posedge clk);
    if (v) model_accept(d, k, |(de | nt));
    else begin e_valid = 0; e_realign = 0; end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    realign_cnt = 0;
  endtask

  logic [8*B-1:0] last_d, d;
  logic [B-1:0]   kk, de, nt;
  int             cur_pos, vcnt;

  initial begin
    model_reset();
    do_reset();

    // Offset 2 lock and repack
    repeat (3) send(1, 32'h00BC1100, 4'b0100, 0, 0);
    check("t1_offset", offset_out, 2);
    check("t1_locked", locked_out, 1);
    check("t1_realign_cnt", realign_cnt, 1);
    send(1, 32'h77665544, 4'b0000, 0, 0);
    check("t1_data", aligned_data_out, 32'h554400BC);
    check("t1_charisk", aligned_charisk_out, 4'b0001);

    // Offset 0: output is the input delayed
    do_reset();
    repeat (3) send(1, 32'h332211BC, 4'b0001, 0, 0);
    check("t2_locked", locked_out, 1);
    check("t2_offset", offset_out, 0);
    last_d = 32'h332211BC;
    for (int i = 0; i < 4; i++) begin
      d = {24'($urandom_range(0, 32'h00FFFFFF)) & 24'h7F7F7F, 8'hBC};
      send(1, d, 4'b0001, 0, 0);
      check("t2_delay", aligned_data_out, last_d);
      last_d = d;
    end
    check("t2_no_realign", realign_cnt, 0);

    // Unlock by errors interleaved with comma-free good words
    for (int i = 0; i < 4; i++) begin
      send(1, 32'h12345678, 4'b0000, 4'b0010, 0);
      if (i < 3) send(1, 32'h0A0B0C0D, 4'b0000, 0, 0);
    end
    check("t3_unlocked", locked_out, 0);
    check("t3_valid_low", aligned_valid_out, 0);
    check("t3_err_count", err_count_out, 4);
    // A good comma after 3 errors clears the bad count
    repeat (3) send(1, 32'h332211BC, 4'b0001, 0, 0);
    repeat (3) send(1, 32'h12345678, 4'b0000, 0, 4'b1000);
    send(1, 32'h332211BC, 4'b0001, 0, 0);
    repeat (3) send(1, 32'h12345678, 4'b0000, 4'b0001, 0);
    check("t3_survives", locked_out, 1);
    check("t3_err_count2", err_count_out, 10);

    // Offset shift from 2 to 1
    do_reset();
    repeat (3) send(1, 32'h00BC1100, 4'b0100, 0, 0);
    repeat (4) send(1, 32'h0000BC00, 4'b0010, 0, 0);
    check("t4_dropped", locked_out, 0);
    send(1, 32'h0000BC00, 4'b0010, 0, 0);
    check("t4_realign", realign_out, 1);
    check("t4_offset", offset_out, 1);
    send(1, 32'h0000BC00, 4'b0010, 0, 0);
    check("t4_not_yet", locked_out, 0);
    send(1, 32'h0000BC00, 4'b0010, 0, 0);
    check("t4_relocked", locked_out, 1);

    // Gaps during lock-in
    do_reset();
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      send(0, 32'hBC000000, 4'b1000, 0, 0);
      check("t5_gap_valid", aligned_valid_out, 0);
      if (i < 2 && aligned_valid_out) vcnt++;
      send(1, 32'hBC000000, 4'b1000, 0, 0);
      if (i < 2 && aligned_valid_out) vcnt++;
    end
    check("t5_no_spurious", vcnt, 0);
    check("t5_locked", locked_out, 1);
    check("t5_offset", offset_out, 3);
    send(0, 32'hBC000000, 4'b1000, 0, 0);
    check("t5_gap_locked", aligned_valid_out, 0);
    // Multiple commas: lowest index wins
    do_reset();
    send(1, 32'hBC00BC00, 4'b1010, 0, 0);
    check("t5_multi_pos", offset_out, 1);

    // Reset while locked
    do_reset();
    repeat (3) send(1, 32'h00BC1100, 4'b0100, 0, 0);
    send(1, 32'h00BC1100, 4'b0100, 4'b0001, 0);
    check("t6_err_before", err_count_out, 1);
    do_reset();
    check("t6_locked0", locked_out, 0);
    check("t6_err0", err_count_out, 0);
    check("t6_data0", aligned_data_out, 0);
    check("t6_offset0", offset_out, 0);
    repeat (2) send(1, 32'h00BC1100, 4'b0100, 0, 0);
    check("t6_not_yet", locked_out, 0);
    send(1, 32'h00BC1100, 4'b0100, 0, 0);
    check("t6_relocked", locked_out, 1);

    // Randomized run
    do_reset();
    cur_pos = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) cur_pos = $urandom_range(0, B - 1);
      d  = $urandom;
      kk = '0;
      for (int b = 0; b < B; b++) if ($urandom_range(0, 9) == 0) kk[b] = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        d[8*cur_pos +: 8] = 8'hBC;
        kk[cur_pos] = 1'b1;
      end
      de = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      nt = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      send($urandom_range(0, 99) < 85, d, kk, de, nt);
    end
    check("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
